seg_scan_decoder: RTL and testbench

//   Receive-side counterpart of the hex-to-segment encoder. Watches a multiplexed 7-segment bus
//   (segment lines plus one-hot digit select) and recovers the hex value shown on each digit.

---
 rtl/seg_scan_decoder_pkg.sv | 29 ++
 rtl/seg_glyph_decode.sv | 39 +++
 rtl/seg_scan_decoder.sv | 134 +++++++++++++
 tb/tb_seg_scan_decoder.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_decoder_pkg.sv
// Shared glyph table and decode result type for the 7-segment scan decoder.
// Segment order is {a,b,c,d,e,f,g}, active high, identical to the encoder side.
package seg_scan_decoder_pkg;

    localparam logic [6:0] SEG_0     = 7'b1111110;
    localparam logic [6:0] SEG_1     = 7'b0110000;
    localparam logic [6:0] SEG_2     = 7'b1101101;
    localparam logic [6:0] SEG_3     = 7'b1111001;
    localparam logic [6:0] SEG_4     = 7'b0110011;
    localparam logic [6:0] SEG_5     = 7'b1011011;
    localparam logic [6:0] SEG_6     = 7'b1011111;
    localparam logic [6:0] SEG_7     = 7'b1110000;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1111011;
    localparam logic [6:0] SEG_A     = 7'b1110111;
    localparam logic [6:0] SEG_B     = 7'b0011111;
    localparam logic [6:0] SEG_C     = 7'b1001110;
    localparam logic [6:0] SEG_D     = 7'b0111101;
    localparam logic [6:0] SEG_E     = 7'b1001111;
    localparam logic [6:0] SEG_F     = 7'b1000111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef struct packed {
        logic       legal;
        logic       blank;
        logic [3:0] hex;
    } glyph_t;

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational inverse of the hex-to-segment encoder table.
// Anything that is neither a hex glyph nor all-off decodes as illegal.
module seg_glyph_decode
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] seg_i,
    output glyph_t     glyph_o
);

    always_comb begin
        glyph_o.legal = 1'b1;
        glyph_o.blank = 1'b0;
        glyph_o.hex   = 4'h0;
        case (seg_i)
            SEG_0:     glyph_o.hex = 4'h0;
            SEG_1:     glyph_o.hex = 4'h1;
            SEG_2:     glyph_o.hex = 4'h2;
            SEG_3:     glyph_o.hex = 4'h3;
            SEG_4:     glyph_o.hex = 4'h4;
            SEG_5:     glyph_o.hex = 4'h5;
            SEG_6:     glyph_o.hex = 4'h6;
            SEG_7:     glyph_o.hex = 4'h7;
            SEG_8:     glyph_o.hex = 4'h8;
            SEG_9:     glyph_o.hex = 4'h9;
            SEG_A:     glyph_o.hex = 4'hA;
            SEG_B:     glyph_o.hex = 4'hB;
            SEG_C:     glyph_o.hex = 4'hC;
            SEG_D:     glyph_o.hex = 4'hD;
            SEG_E:     glyph_o.hex = 4'hE;
            SEG_F:     glyph_o.hex = 4'hF;
            SEG_BLANK: begin
                glyph_o.legal = 1'b0;
                glyph_o.blank = 1'b1;
            end
            default:   glyph_o.legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers per-digit hex values from a multiplexed 7-segment bus: samples the bus,
// debounces each {dig_sel,seg_in} pattern and commits the decoded glyph once per stable window.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter  int NUM_DIGITS    = 4,
    parameter  int STABLE_CYCLES = 4,
    localparam int CNT_W         = $clog2(STABLE_CYCLES + 1),
    localparam int IDX_W         = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits_o,
    output logic [NUM_DIGITS-1:0]   valid_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic                    err_o,
    output logic                    upd_o,
    output logic [IDX_W-1:0]        upd_idx
);

    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [6:0]              seg_q, seg_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   valid_q, valid_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic                    err_q, err_d;
    logic                    upd_q, upd_d;
    logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;

    logic                    smp_onehot;
    logic                    smp_same;
    logic                    commit;
    logic [IDX_W-1:0]        smp_idx;
    glyph_t                  glyph;

    // Decoding the live input is equivalent to decoding s_q on a commit edge,
    // because a commit requires the incoming sample to equal s_q.
    seg_glyph_decode u_glyph_decode (
        .seg_i   (seg_in),
        .glyph_o (glyph)
    );

    always_comb begin
        smp_onehot = ($countones(dig_sel) == 1);
        smp_same   = (dig_sel == sel_q) && (seg_in == seg_q);
        smp_idx    = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_sel[i]) smp_idx = IDX_W'(i);
        end
        commit = smp_onehot && smp_same && (cnt_q == CNT_W'(STABLE_CYCLES - 1));
    end

    always_comb begin
        sel_d     = dig_sel;
        seg_d     = seg_in;
        cnt_d     = cnt_q;
        digits_d  = digits_q;
        valid_d   = valid_q;
        blank_d   = blank_q;
        err_d     = err_q;
        upd_d     = 1'b0;
        upd_idx_d = upd_idx_q;

        if (!smp_onehot) begin
            cnt_d = '0;
        end else if (!smp_same) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q < CNT_W'(STABLE_CYCLES)) begin
            cnt_d = cnt_q + 1'b1;
        end

        if (commit) begin
            upd_d     = 1'b1;
            upd_idx_d = smp_idx;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (dig_sel[i]) begin
                    valid_d[i] = glyph.legal;
                    blank_d[i] = glyph.blank;
                    if (glyph.legal) digits_d[4*i +: 4] = glyph.hex;
                end
            end
            if (!glyph.legal && !glyph.blank) err_d = 1'b1;
        end

        // Clear dominates a simultaneous commit.
        if (clear) begin
            sel_d     = '0;
            seg_d     = '0;
            cnt_d     = '0;
            digits_d  = '0;
            valid_d   = '0;
            blank_d   = '0;
            err_d     = 1'b0;
            upd_d     = 1'b0;
            upd_idx_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q     <= '0;
            seg_q     <= '0;
            cnt_q     <= '0;
            digits_q  <= '0;
            valid_q   <= '0;
            blank_q   <= '0;
            err_q     <= 1'b0;
            upd_q     <= 1'b0;
            upd_idx_q <= '0;
        end else begin
            sel_q     <= sel_d;
            seg_q     <= seg_d;
            cnt_q     <= cnt_d;
            digits_q  <= digits_d;
            valid_q   <= valid_d;
            blank_q   <= blank_d;
            err_q     <= err_d;
            upd_q     <= upd_d;
            upd_idx_q <= upd_idx_d;
        end
    end

    assign digits_o = digits_q;
    assign valid_o  = valid_q;
    assign blank_o  = blank_q;
    assign err_o    = err_q;
    assign upd_o    = upd_q;
    assign upd_idx  = upd_idx_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: glyph table vectors, directed corner sequences and
// randomized bus traffic checked against a run-length based reference model.
module tb_seg_scan_decoder;

    localparam int ND = 4;
    localparam int SC = 4;

    logic            clk;
    logic            rst_n;
    logic [6:0]      seg_in;
    logic [ND-1:0]   dig_sel;
    logic            clear;
    logic [4*ND-1:0] digits_o;
    logic [ND-1:0]   valid_o;
    logic [ND-1:0]   blank_o;
    logic            err_o;
    logic            upd_o;
    logic [1:0]      upd_idx;

    seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .seg_in   (seg_in),
        .dig_sel  (dig_sel),
        .clear    (clear),
        .digits_o (digits_o),
        .valid_o  (valid_o),
        .blank_o  (blank_o),
        .err_o    (err_o),
        .upd_o    (upd_o),
        .upd_idx  (upd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Glyphs written out independently of the design package.
    logic [6:0] lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    int checks = 0;
    int errors = 0;
    int upd_seen = 0;

    // Reference model: length of the current run of identical samples.
    logic [ND-1:0] m_sel;
    logic [6:0]    m_seg;
    int            m_run;
    logic [3:0]    m_dig [ND];
    logic [ND-1:0] m_valid, m_blank;
    logic          m_err, m_upd;
    int            m_idx;

    task automatic model_reset();
        m_sel = '0; m_seg = '0; m_run = 0;
        for (int i = 0; i < ND; i++) m_dig[i] = 4'h0;
        m_valid = '0; m_blank = '0; m_err = 1'b0; m_upd = 1'b0; m_idx = 0;
    endtask

    task automatic model_step();
        int hex;
        if (!rst_n || clear) begin
            model_reset();
            return;
        end
        if ($countones(dig_sel) != 1) m_run = 0;
        else if (dig_sel == m_sel && seg_in == m_seg) m_run++;
        else m_run = 1;
        m_sel = dig_sel;
        m_seg = seg_in;
        m_upd = (m_run == SC);
        if (m_upd) begin
            for (int i = 0; i < ND; i++) if (dig_sel[i]) m_idx = i;
            hex = -1;
            for (int h = 0; h < 16; h++) if (lut[h] == seg_in) hex = h;
            if (hex >= 0) begin
                m_dig[m_idx] = 4'(hex);
                m_valid[m_idx] = 1'b1;
                m_blank[m_idx] = 1'b0;
            end else begin
                m_valid[m_idx] = 1'b0;
                m_blank[m_idx] = (seg_in == 7'h00);
                if (seg_in != 7'h00) m_err = 1'b1;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
        end
    endtask

    task automatic check_all();
        logic [4*ND-1:0] exp_d;
        for (int i = 0; i < ND; i++) exp_d[4*i +: 4] = m_dig[i];
        cmp("digits_o", 32'(digits_o), 32'(exp_d));
        cmp("valid_o",  32'(valid_o),  32'(m_valid));
        cmp("blank_o",  32'(blank_o),  32'(m_blank));
        cmp("err_o",    32'(err_o),    32'(m_err));
        cmp("upd_o",    32'(upd_o),    32'(m_upd));
        if (m_upd) cmp("upd_idx", 32'(upd_idx), 32'(m_idx));
    endtask

    task automatic cycle(input logic [ND-1:0] sel, input logic [6:0] seg, input logic clr);
        dig_sel = sel; seg_in = seg; clear = clr;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        if (upd_o) upd_seen++;
    endtask

    task automatic hold(input logic [ND-1:0] sel, input logic [6:0] seg, input int n);
        for (int k = 0; k < n; k++) cycle(sel, seg, 1'b0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        cycle(4'($urandom), 7'($urandom), 1'($urandom));
        cycle(4'($urandom), 7'($urandom), 1'($urandom));
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [6:0] seg;
        logic       legal;
        logic       blank;
        logic [3:0] hex;
    } vec_t;

    vec_t tbl [19];

    initial begin
        int n0;
        model_reset();
        rst_n = 1'b0; dig_sel = '0; seg_in = '0; clear = 1'b0;
        for (int i = 0; i < 16; i++) tbl[i] = '{lut[i], 1'b1, 1'b0, 4'(i)};
        tbl[16] = '{7'h00, 1'b0, 1'b1, 4'h0};
        tbl[17] = '{7'h55, 1'b0, 1'b0, 4'h0};
        tbl[18] = '{7'h01, 1'b0, 1'b0, 4'h0};

        // Reset with random inputs, then release: nothing until a commit.
        for (int k = 0; k < 5; k++) cycle(4'($urandom), 7'($urandom), 1'($urandom));
        #1;
        cmp("reset_digits", 32'(digits_o), 32'h0);
        cmp("reset_flags", 32'({valid_o, blank_o, err_o, upd_o}), 32'h0);
        rst_n = 1'b1;
        hold(4'b0100, lut[7], 3);
        cmp("post_reset_valid", 32'(valid_o), 32'h0);

        // Single commit of "3" on digit 1.
        cycle(4'b0000, 7'h00, 1'b1);
        upd_seen = 0;
        hold(4'b0010, 7'b1111001, 4);
        cmp("t2_upd", 32'(upd_o), 32'h1);
        cmp("t2_idx", 32'(upd_idx), 32'h1);
        cmp("t2_digit", 32'(digits_o[7:4]), 32'h3);
        cmp("t2_valid", 32'(valid_o), 32'h2);
        hold(4'b0010, 7'b1111001, 4);
        cmp("t2_once", 32'(upd_seen), 32'h1);

        // Glitch: "8" for 2 cycles then "9" for 4 on digit 0.
        upd_seen = 0;
        hold(4'b0001, lut[8], 2);
        hold(4'b0001, lut[9], 4);
        cmp("t3_count", 32'(upd_seen), 32'h1);
        cmp("t3_digit", 32'(digits_o[3:0]), 32'h9);

        // Glyph table vectors.
        for (int v = 0; v < 19; v++) begin
            cycle(4'b0000, 7'h00, 1'b1);
            hold(4'(1 << (v % 4)), tbl[v].seg, SC);
            cmp("tbl_upd", 32'(upd_o), 32'h1);
            cmp("tbl_idx", 32'(upd_idx), 32'(v % 4));
            cmp("tbl_valid", 32'(valid_o[v % 4]), 32'(tbl[v].legal));
            cmp("tbl_blank", 32'(blank_o[v % 4]), 32'(tbl[v].blank));
            cmp("tbl_err", 32'(err_o), 32'(!tbl[v].legal && !tbl[v].blank));
            if (tbl[v].legal) cmp("tbl_hex", 32'(digits_o[4*(v%4) +: 4]), 32'(tbl[v].hex));
        end

        // Illegal glyph on digit 2 after a legal "5".
        cycle(4'b0000, 7'h00, 1'b1);
        hold(4'b0100, lut[5], 4);
        hold(4'b0100, 7'b1010101, 4);
        cmp("t4_err", 32'(err_o), 32'h1);
        cmp("t4_valid2", 32'(valid_o[2]), 32'h0);
        cmp("t4_keep", 32'(digits_o[11:8]), 32'h5);
        hold(4'b0001, lut[1], 6);
        cmp("t4_sticky", 32'(err_o), 32'h1);

        // Non-one-hot selects never commit; blank on digit 3.
        upd_seen = 0;
        hold(4'b0000, lut[2], 10);
        hold(4'b0101, lut[2], 10);
        cmp("t5_noupd", 32'(upd_seen), 32'h0);
        hold(4'b1000, 7'h00, 4);
        cmp("t5_blank3", 32'(blank_o[3]), 32'h1);

        // Scan "A","b","C","d" three passes, 4 cycles per slot.
        cycle(4'b0000, 7'h00, 1'b1);
        for (int p = 0; p < 3; p++) begin
            upd_seen = 0;
            for (int d = 0; d < 4; d++) hold(4'(1 << d), lut[10 + d], 4);
            cmp("t6_pass_commits", 32'(upd_seen), 32'h4);
        end
        cmp("t6_digits", 32'(digits_o), 32'hDCBA);
        upd_seen = 0;
        for (int d = 0; d < 4; d++) hold(4'(1 << d), lut[d], 3);
        cmp("t6_short_slots", 32'(upd_seen), 32'h0);
        hold(4'b0001, lut[1], 3);
        cycle(4'b0001, lut[1], 1'b1);
        cmp("t6_clr_upd", 32'(upd_o), 32'h0);
        cmp("t6_clr_all", 32'({digits_o, valid_o, blank_o, err_o}), 32'h0);

        // Reset in the middle of a window.
        hold(4'b0010, lut[6], 2);
        async_reset();
        hold(4'b0010, lut[6], 3);
        cmp("mid_reset_noupd", 32'(valid_o), 32'h0);
        hold(4'b0010, lut[6], 1);
        cmp("mid_reset_commit", 32'(upd_o), 32'h1);

        // Randomized traffic.
        for (int s = 0; s < 160; s++) begin
            logic [ND-1:0] sel;
            logic [6:0]    seg;
            int            r;
            r = $urandom_range(0, 9);
            if (r < 8) sel = 4'(1 << $urandom_range(0, 3));
            else if (r == 8) sel = '0;
            else sel = 4'b0110 | 4'($urandom_range(0, 15));
            r = $urandom_range(0, 11);
            if (r < 10) seg = lut[$urandom_range(0, 15)];
            else if (r == 10) seg = 7'h00;
            else seg = 7'($urandom);
            n0 = $urandom_range(1, 6);
            for (int k = 0; k < n0; k++) cycle(sel, seg, ($urandom_range(0, 59) == 0));
            if ($urandom_range(0, 39) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
